// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-attached command RAM.
// Command codes carried in din[DATA_W+1:DATA_W] and controller states.
package spi_ram_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/sp_ram.sv
// Plain single-port synchronous RAM, registered read, no reset.
// Ports: clk, we, addr[ADDR_W], wdata[DATA_W], rdata[DATA_W] (registered).
module sp_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command-decoded RAM behind the SPI slave: address/data commands,
// optional post-reset clear, auto-increment, read-before-address error.
// Ports: clk, rst_n (sync, active-low), din{cmd,field}, rx_valid,
//        dout, tx_valid (1-cycle), busy (clearing), cmd_err (1-cycle).
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int AUTO_INC       = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W+1:0] din,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    output logic              busy,
    output logic              cmd_err
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam state_t ST_INIT = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
    localparam logic BUSY_INIT = (CLEAR_ON_RESET != 0);

    state_t            state;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] clr_addr;
    logic              rd_addr_set;
    logic [DATA_W-1:0] dout_hold;

    logic [1:0]        cmd;
    logic [DATA_W-1:0] field;
    logic              run_cmd;
    logic              wr_data_cmd;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    assign cmd         = din[DATA_W+1:DATA_W];
    assign field       = din[DATA_W-1:0];
    assign run_cmd     = (state == ST_RUN) && rx_valid;
    assign wr_data_cmd = run_cmd && (cmd == CMD_WR_DATA);

    // Writes are held off while rst_n is low so a reset cycle never
    // disturbs memory contents.
    assign ram_we = rst_n && ((state == ST_CLEAR) || wr_data_cmd);

    always_comb begin
        ram_addr  = rd_addr;
        ram_wdata = field;
        unique case (1'b1)
            (state == ST_CLEAR): begin
                ram_addr  = clr_addr;
                ram_wdata = '0;
            end
            wr_data_cmd: begin
                ram_addr = wr_addr;
            end
            default: begin
                ram_addr = rd_addr;
            end
        endcase
    end

    sp_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // The RAM output register carries fresh data exactly in the
    // tx_valid cycle; dout_hold keeps it afterwards so dout is stable
    // between reads and zero out of reset.
    assign dout = tx_valid ? ram_rdata : dout_hold;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_INIT;
            busy        <= BUSY_INIT;
            wr_addr     <= '0;
            rd_addr     <= '0;
            rd_addr_set <= 1'b0;
            clr_addr    <= '0;
            tx_valid    <= 1'b0;
            cmd_err     <= 1'b0;
            dout_hold   <= '0;
        end else begin
            tx_valid <= 1'b0;
            cmd_err  <= 1'b0;
            if (tx_valid) begin
                dout_hold <= ram_rdata;
            end
            case (state)
                ST_CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    cmd_err  <= rx_valid;
                    if (clr_addr == ADDR_MAX) begin
                        state <= ST_RUN;
                        busy  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (rx_valid) begin
                        case (cmd)
                            CMD_WR_ADDR: begin
                                wr_addr <= field[ADDR_W-1:0];
                            end
                            CMD_WR_DATA: begin
                                if (AUTO_INC != 0) begin
                                    wr_addr <= wr_addr + 1'b1;
                                end
                            end
                            CMD_RD_ADDR: begin
                                rd_addr     <= field[ADDR_W-1:0];
                                rd_addr_set <= 1'b1;
                            end
                            default: begin
                                if (rd_addr_set) begin
                                    tx_valid <= 1'b1;
                                    if (AUTO_INC != 0) begin
                                        rd_addr <= rd_addr + 1'b1;
                                    end
                                end else begin
                                    cmd_err <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed self-checking bench for spi_ram_ctrl: one instance with
// auto-increment, one with held addresses, both clearing on reset.
module tb_spi_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] din1, din2;
    logic       rx1, rx2;
    logic [7:0] dout1, dout2;
    logic       tx1, tx2, busy1, busy2, err1, err2;

    int tests = 0;
    int fails = 0;
    int n;

    always #5 clk = ~clk;

    spi_ram_ctrl #(
        .ADDR_W(8), .DATA_W(8), .AUTO_INC(1), .CLEAR_ON_RESET(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .din(din1), .rx_valid(rx1),
        .dout(dout1), .tx_valid(tx1), .busy(busy1), .cmd_err(err1)
    );

    spi_ram_ctrl #(
        .ADDR_W(8), .DATA_W(8), .AUTO_INC(0), .CLEAR_ON_RESET(1)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .din(din2), .rx_valid(rx2),
        .dout(dout2), .tx_valid(tx2), .busy(busy2), .cmd_err(err2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmd1(input logic [1:0] c, input logic [7:0] f);
        rx1  = 1'b1;
        din1 = {c, f};
        tick();
        rx1  = 1'b0;
    endtask

    task automatic cmd2(input logic [1:0] c, input logic [7:0] f);
        rx2  = 1'b1;
        din2 = {c, f};
        tick();
        rx2  = 1'b0;
    endtask

    task automatic wait_clear(output int cnt);
        cnt = 0;
        while (busy1 && cnt < 400) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rx1 = 1'b0; rx2 = 1'b0;
        din1 = '0;  din2 = '0;
        tick();
        tick();
        chk("rst_busy", {31'd0, busy1}, 32'd1);
        chk("rst_tx", {31'd0, tx1}, 32'd0);
        chk("rst_err", {31'd0, err1}, 32'd0);
        chk("rst_dout", {24'd0, dout1}, 32'd0);

        // Clear sequence with a command dropped at cycle 10.
        rst_n = 1'b1;
        n = 0;
        while (n < 400) begin
            tick();
            n++;
            if (n == 9) begin
                rx1  = 1'b1;
                din1 = 10'h012;
            end
            if (n == 10) begin
                chk("clr_err_pulse", {31'd0, err1}, 32'd1);
                chk("clr_busy_mid", {31'd0, busy1}, 32'd1);
                rx1 = 1'b0;
            end
            if (n == 11) begin
                chk("clr_err_end", {31'd0, err1}, 32'd0);
            end
            if (!busy1) break;
        end
        chk("clr_len", n, 32'd256);
        chk("clr_busy2", {31'd0, busy2}, 32'd0);

        // Read before any read address.
        cmd1(2'b11, 8'h00);
        chk("rbA_err", {31'd0, err1}, 32'd1);
        chk("rbA_tx", {31'd0, tx1}, 32'd0);
        chk("rbA_dout", {24'd0, dout1}, 32'd0);
        tick();
        chk("rbA_err_end", {31'd0, err1}, 32'd0);

        // Dropped WR_ADDR left wr_addr at 0: this lands in RAM[0].
        cmd1(2'b01, 8'h3C);
        cmd1(2'b10, 8'h7F);
        cmd1(2'b11, 8'h00);
        chk("rd7F_tx", {31'd0, tx1}, 32'd1);
        chk("rd7F_dout", {24'd0, dout1}, 32'd0);
        cmd1(2'b10, 8'h00);
        cmd1(2'b11, 8'h00);
        chk("rd00_tx", {31'd0, tx1}, 32'd1);
        chk("rd00_dout", {24'd0, dout1}, 32'h3C);

        // Burst with wrap.
        cmd1(2'b00, 8'hFE);
        cmd1(2'b01, 8'hA1);
        cmd1(2'b01, 8'hA2);
        cmd1(2'b01, 8'hA3);
        cmd1(2'b10, 8'hFE);
        cmd1(2'b11, 8'h00);
        chk("bst0_tx", {31'd0, tx1}, 32'd1);
        chk("bst0_dout", {24'd0, dout1}, 32'hA1);
        cmd1(2'b11, 8'h00);
        chk("bst1_tx", {31'd0, tx1}, 32'd1);
        chk("bst1_dout", {24'd0, dout1}, 32'hA2);
        cmd1(2'b11, 8'h00);
        chk("bst2_tx", {31'd0, tx1}, 32'd1);
        chk("bst2_dout", {24'd0, dout1}, 32'hA3);
        din1 = 10'h300;
        tick();
        chk("idle_tx", {31'd0, tx1}, 32'd0);
        chk("idle_hold", {24'd0, dout1}, 32'hA3);

        // Read-after-write, same address, consecutive cycles.
        cmd1(2'b00, 8'h40);
        cmd1(2'b10, 8'h40);
        cmd1(2'b01, 8'h5A);
        cmd1(2'b11, 8'h00);
        chk("raw_dout", {24'd0, dout1}, 32'h5A);

        // Held addresses on the second instance.
        cmd2(2'b00, 8'h10);
        cmd2(2'b01, 8'h55);
        cmd2(2'b01, 8'h66);
        cmd2(2'b10, 8'h10);
        cmd2(2'b11, 8'h00);
        chk("hold_tx", {31'd0, tx2}, 32'd1);
        chk("hold_dout", {24'd0, dout2}, 32'h66);
        cmd2(2'b11, 8'h00);
        chk("hold_again", {24'd0, dout2}, 32'h66);
        cmd2(2'b10, 8'h11);
        cmd2(2'b11, 8'h00);
        chk("hold_next", {24'd0, dout2}, 32'h00);

        // Reset in the middle of a read burst.
        cmd1(2'b10, 8'hFE);
        cmd1(2'b11, 8'h00);
        chk("mid_tx", {31'd0, tx1}, 32'd1);
        chk("mid_dout", {24'd0, dout1}, 32'hA1);
        rx1   = 1'b1;
        din1  = 10'h300;
        rst_n = 1'b0;
        tick();
        rx1   = 1'b0;
        rst_n = 1'b1;
        chk("mrst_tx", {31'd0, tx1}, 32'd0);
        chk("mrst_dout", {24'd0, dout1}, 32'd0);
        chk("mrst_busy", {31'd0, busy1}, 32'd1);
        wait_clear(n);
        chk("mrst_len", n, 32'd256);
        cmd1(2'b11, 8'h00);
        chk("mrst_rbA", {31'd0, err1}, 32'd1);
        cmd1(2'b10, 8'hFE);
        cmd1(2'b11, 8'h00);
        chk("mrst_clr", {24'd0, dout1}, 32'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
Parametrised command-decoded single-port synchronous RAM behind the SPI slave. It consumes {cmd[1:0], field} words with rx_valid and returns read data with a one-cycle tx_valid pulse. It adds several features over the first-generation memory: sequential post-reset clear, address auto-increment for bursts, read-before-address error detection, and fully rx_valid-qualified commands.

Parameters:
ADDR_W, 8, address width; depth = 2**ADDR_W.
DATA_W, 8, data width; must be >= ADDR_W.
AUTO_INC, 1, 1 = write/read address post-increments after each data command; 0 = address held.
CLEAR_ON_RESET, 1, 1 = sequentially zero the whole array after reset; 0 = contents undefined, no clear.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  synchronous active-low reset.
din  input  DATA_W+2  [DATA_W+1:DATA_W] = cmd, [DATA_W-1:0] = field (address in low ADDR_W bits).
rx_valid  input  1  din valid this cycle; one command per cycle.
dout  output  DATA_W  read data, registered.
tx_valid  output  1  one-cycle pulse, dout valid.
busy  output  1  clear in progress; commands are not accepted.
cmd_err  output  1  one-cycle pulse on a dropped or illegal command.

Behaviour:
- Clock clk; reset rst_n is synchronous, active-low, sampled on the rising edge of clk only.
- Reset values: dout=0, tx_valid=0, cmd_err=0, wr_addr=0, rd_addr=0, rd_addr_set=0, clr_addr=0.
- busy reset value: 1 if CLEAR_ON_RESET, else 0.
- RAM contents are never reset directly.
- FSM states: CLEAR, RUN.
  - On reset, the FSM enters CLEAR if CLEAR_ON_RESET, else RUN.
  - CLEAR: each cycle write RAM[clr_addr]=0 and clr_addr++. After writing address 2**ADDR_W-1, the next state is RUN and busy drops the same edge.
  - CLEAR therefore lasts exactly 2**ADDR_W cycles after reset release.
  - Reset asserted mid-CLEAR restarts the clear from address 0.
- In CLEAR, rx_valid=1: command dropped, cmd_err pulses next cycle, no state change.
- In RUN, commands act only when rx_valid=1. rx_valid=0 leaves all state unchanged and tx_valid/cmd_err are 0.
  - cmd 00 (WR_ADDR): wr_addr <= field[ADDR_W-1:0].
  - cmd 01 (WR_DATA): RAM[wr_addr] <= field. If AUTO_INC, wr_addr++ (wraps 2**ADDR_W-1 -> 0).
  - cmd 10 (RD_ADDR): rd_addr <= field[ADDR_W-1:0]; rd_addr_set <= 1.
  - cmd 11 (RD_DATA):
    - If rd_addr_set: dout <= RAM[rd_addr] and tx_valid=1 on the next cycle (latency 1 from the command edge). If AUTO_INC, rd_addr++ with wrap.
    - If !rd_addr_set: no read, dout held, cmd_err pulses.
- Back-to-back RD_DATA in consecutive cycles produces consecutive tx_valid pulses, one per command.
- Read-after-write: a WR_DATA in cycle N followed by RD_DATA of the same address in N+1 returns the new data.
- dout holds its last value between reads.
- Unused field bits above ADDR_W in address commands are ignored.

Decomposition:
- Package spi_ram_pkg: cmd localparams CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11; FSM state encoding ST_CLEAR, ST_RUN.
- Sub-module sp_ram: plain single-port synchronous RAM (we, addr, wdata, rdata registered, no reset), parametrised ADDR_W/DATA_W.
- The controller muxes clr_addr/wr_addr/rd_addr onto the single port.

Test Plan:
- Reset with CLEAR_ON_RESET=1, depth 256: busy=1 for exactly 256 cycles after rst_n rises. Then RD_ADDR 0x7F followed by RD_DATA gives dout=0x00 with tx_valid one cycle later.
- Command during CLEAR: rx_valid with din=10'h0_12 at cycle 10 → cmd_err pulse at cycle 11, and wr_addr is still 0 after CLEAR.
- Burst write/read with AUTO_INC=1:
  - Stimulus: WR_ADDR 0xFE, WR_DATA 0xA1, 0xA2, 0xA3, then RD_ADDR 0xFE and three back-to-back RD_DATA.
  - Required: three consecutive tx_valid pulses with dout 0xA1, 0xA2, 0xA3 (addresses 0xFE, 0xFF, 0x00 wrap).
- RD_DATA before any RD_ADDR after reset → cmd_err=1 for one cycle, tx_valid=0, dout stays 0.
- AUTO_INC=0: WR_ADDR 0x10, WR_DATA 0x55, WR_DATA 0x66, then RD_ADDR 0x10, RD_DATA → dout=0x66; RAM[0x11] unchanged.
- Reset mid-burst: assert rst_n=0 for one cycle during a RD_DATA sequence → next cycle tx_valid=0, dout=0, busy=1, and CLEAR restarts from 0.
